noc_cycle_sequencer: RTL and testbench
======================================

// Module: noc_cycle_sequencer
// PURPOSE
//   Top-level sequencer for the router array. Broadcasts the op/data/in_cycle command bus to all routers.
//   Per run: issues Init, streams routing-table entries (LoadRt) to the selected router, then per simulated
//   cycle issues LoadStaging -> Phase0 -> Phase1 and waits for every router's done before advancing in_cycle.
//   Owns the global cycle counter, the run-completion flag and the stall timeout.
// PARAMETERS
//   NUM_ROUTERS  16    routers driven; width of router_done and rt_sel
//   TIMEOUT      1024  max WAIT_DONE cycles before timeout_err; 0 disables timeout
// PORTS
//   clk          in   1            single clock, rising edge
//   rst_n        in   1            asynchronous, active-low reset
//   start        in   1            level sampled in IDLE only; launches a run
//   num_cycles   in   14           cycles to simulate, latched when start is accepted
//   rt_valid     in   1            routing entry on rt_data/rt_dest valid
//   rt_ready     out  1            sequencer accepts entry (high only in LOAD_RT)
//   rt_data      in   32           entry payload: [13:0] dest, [19:14] out_port, rest 0
//   rt_dest      in   clog2(NUM_ROUTERS)  index of router receiving the entry
//   rt_last      in   1            entry is the final one of the table load
//   router_done  in   NUM_ROUTERS  per-router done, one bit per router
//   op           out  3            broadcast router opcode (`NOP/`Init/`LoadRt/`LoadStaging/`Phase0/`Phase1)
//   data         out  32           broadcast router data word
//   rt_sel       out  NUM_ROUTERS  one-hot router enable during LoadRt; all-ones for every other op
//   in_cycle     out  14           current simulated cycle, broadcast to routers
//   busy         out  1            high in every state except IDLE
//   sim_done     out  1            one-cycle pulse when the run completes (normally or on timeout)
//   timeout_err  out  1            sticky; set on WAIT_DONE timeout, cleared on next accepted start
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, op=`NOP, data=0, rt_sel=0, in_cycle=0, rt_ready=0, busy=0,
//     sim_done=0, timeout_err=0, wait counter=0. Reset mid-run aborts immediately; no pulse on sim_done.
//   All outputs are registered; op/data/rt_sel change on the clk edge that enters a state.
//   FSM:
//     IDLE    op=`NOP. start=1 -> INIT; latch num_cycles, clear in_cycle and timeout_err.
//     INIT    op=`Init for exactly 1 cycle, rt_sel=all-ones -> LOAD_RT.
//     LOAD_RT rt_ready=1. Cycle with rt_valid=1: next cycle op=`LoadRt, data=rt_data,
//             rt_sel=1<<rt_dest (1 cycle per entry, back-to-back allowed). Cycles with rt_valid=0: op=`NOP, rt_sel=0.
//             Accepted entry with rt_last=1 -> STAGE, or -> FINISH if latched num_cycles==0.
//             rt_dest>=NUM_ROUTERS: entry consumed, rt_sel=0 (dropped).
//     STAGE   op=`LoadStaging 1 cycle -> PH0.
//     PH0     op=`Phase0 1 cycle -> PH1.
//     PH1     op=`Phase1 1 cycle -> WAIT_DONE; wait counter cleared.
//     WAIT_DONE op=`NOP. &router_done=1 -> in_cycle+1; if new in_cycle==num_cycles -> FINISH else STAGE.
//             Otherwise counter+1; counter reaching TIMEOUT-1 (TIMEOUT!=0) -> timeout_err=1, FINISH.
//     FINISH  op=`NOP, sim_done=1 for 1 cycle -> IDLE.
//   data=0 in every state except the LoadRt cycle. rt_ready=0 outside LOAD_RT.
//   Counts: in_cycle 14-bit, never exceeds num_cycles, so no wrap. num_cycles=14'h3FFF allowed.
//   done sampled the same cycle it rises: min per-cycle period = 4 clk (STAGE,PH0,PH1,WAIT_DONE).
//   router_done already all-ones on WAIT_DONE entry: advance after exactly 1 WAIT_DONE cycle.
//   start while busy: ignored. start held high through FINISH: new run begins 1 cycle after IDLE.
// TESTING
//   rst_n=0 mid-PH0 -> same cycle op=`NOP, busy=0, in_cycle=0; rst_n=1 with start=0 keeps IDLE.
//   start, num_cycles=3, 2 rt entries (dest 0,5; last on 2nd), done tied 1 -> op seq Init,LoadRt(sel=0x0001),
//     LoadRt(sel=0x0020), then 3x{LoadStaging,Phase0,Phase1,NOP}; in_cycle 0,1,2,3; sim_done 1 pulse.
//   num_cycles=0, one rt entry with last -> Init, LoadRt, FINISH; no LoadStaging issued; in_cycle stays 0.
//   rt_valid gapped 2 cycles between entries -> op=`NOP, rt_sel=0 during gaps; entries never lost or duplicated.
//   router_done=0xFFFE for 5 cycles then 0xFFFF -> in_cycle advances 6 cycles after entering WAIT_DONE.
//   TIMEOUT=8, router_done stuck 0 -> after 8 WAIT_DONE cycles timeout_err=1, sim_done pulse, IDLE; next start clears it.

Source files
------------

// File: rtl/noc_cycle_sequencer.sv
// noc_cycle_sequencer
// Top-level command sequencer for the router array. Broadcasts op/data/in_cycle
// to every router: Init, routing-table load (LoadRt), then per simulated cycle
// LoadStaging -> Phase0 -> Phase1 followed by a wait for all routers' done.
// Owns the simulated-cycle counter, the completion pulse and the stall timeout.
// Every output is a register; the comb block computes the value each output
// takes in the state being entered, so op/data/rt_sel change on that edge.

module noc_cycle_sequencer #(
    parameter int NUM_ROUTERS = 16,
    parameter int TIMEOUT     = 1024,
    localparam int DEST_W     = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [13:0]            num_cycles,
    input  logic                   rt_valid,
    output logic                   rt_ready,
    input  logic [31:0]            rt_data,
    input  logic [DEST_W-1:0]      rt_dest,
    input  logic                   rt_last,
    input  logic [NUM_ROUTERS-1:0] router_done,
    output logic [2:0]             op,
    output logic [31:0]            data,
    output logic [NUM_ROUTERS-1:0] rt_sel,
    output logic [13:0]            in_cycle,
    output logic                   busy,
    output logic                   sim_done,
    output logic                   timeout_err
);

    // Router opcodes broadcast on op.
    localparam logic [2:0] OP_NOP          = 3'd0;
    localparam logic [2:0] OP_INIT         = 3'd1;
    localparam logic [2:0] OP_LOAD_RT      = 3'd2;
    localparam logic [2:0] OP_LOAD_STAGING = 3'd3;
    localparam logic [2:0] OP_PHASE0       = 3'd4;
    localparam logic [2:0] OP_PHASE1       = 3'd5;

    // Sequencer states. S_RT_LAST is the LoadRt cycle of the final table entry,
    // kept separate so that entry's LoadRt never collides with LoadStaging.
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT      = 4'd1;
    localparam logic [3:0] S_LOAD_RT   = 4'd2;
    localparam logic [3:0] S_RT_LAST   = 4'd3;
    localparam logic [3:0] S_STAGE     = 4'd4;
    localparam logic [3:0] S_PH0       = 4'd5;
    localparam logic [3:0] S_PH1       = 4'd6;
    localparam logic [3:0] S_WAIT_DONE = 4'd7;
    localparam logic [3:0] S_FINISH    = 4'd8;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int             CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [3:0]             state,    state_nxt;
    logic [13:0]            target,   target_nxt;
    logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt;
    logic [13:0]            in_cycle_nxt;
    logic [2:0]             op_nxt;
    logic [31:0]            data_nxt;
    logic [NUM_ROUTERS-1:0] rt_sel_nxt;
    logic                   rt_ready_nxt;
    logic                   busy_nxt;
    logic                   sim_done_nxt;
    logic                   timeout_err_nxt;
    logic [NUM_ROUTERS-1:0] dest_hot;

    // Decode the entry's destination; out-of-range indices select no router.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        dest_hot = '0;
        if (int'(rt_dest) < NUM_ROUTERS) begin
            dest_hot[rt_dest] = 1'b1;
        end
    end

    // Next state plus the registered outputs of the state being entered.
    always_comb begin
        state_nxt       = state;
        target_nxt      = target;
        wait_cnt_nxt    = wait_cnt;
        in_cycle_nxt    = in_cycle;
        timeout_err_nxt = timeout_err;
        op_nxt          = OP_NOP;
        data_nxt        = '0;
        rt_sel_nxt      = '0;
        rt_ready_nxt    = 1'b0;
        sim_done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt       = S_INIT;
                    target_nxt      = num_cycles;
                    in_cycle_nxt    = '0;
                    timeout_err_nxt = 1'b0;
                end
            end
            S_INIT: state_nxt = S_LOAD_RT;
            S_LOAD_RT: begin
                if (rt_valid) begin
                    op_nxt     = OP_LOAD_RT;
                    data_nxt   = rt_data;
                    rt_sel_nxt = dest_hot;
                    if (rt_last) begin
                        state_nxt = S_RT_LAST;
                    end
                end
            end
            S_RT_LAST: state_nxt = (target == 14'd0) ? S_FINISH : S_STAGE;
            S_STAGE:   state_nxt = S_PH0;
            S_PH0:     state_nxt = S_PH1;
            S_PH1: begin
                state_nxt    = S_WAIT_DONE;
                wait_cnt_nxt = '0;
            end
            S_WAIT_DONE: begin
                // done has priority over timeout when both happen in one cycle
                if (&router_done) begin
                    in_cycle_nxt = in_cycle + 14'd1;
                    state_nxt    = (in_cycle_nxt == target) ? S_FINISH : S_STAGE;
                end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                    timeout_err_nxt = 1'b1;
                    state_nxt       = S_FINISH;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        // Fixed per-state broadcasts; LoadRt outputs were set above.
        case (state_nxt)
            S_INIT: begin
                op_nxt     = OP_INIT;
                rt_sel_nxt = '1;
            end
            S_STAGE: begin
                op_nxt     = OP_LOAD_STAGING;
                rt_sel_nxt = '1;
            end
            S_PH0: begin
                op_nxt     = OP_PHASE0;
                rt_sel_nxt = '1;
            end
            S_PH1: begin
                op_nxt     = OP_PHASE1;
                rt_sel_nxt = '1;
            end
            S_LOAD_RT: rt_ready_nxt = 1'b1;
            S_FINISH:  sim_done_nxt = 1'b1;
            default: ;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and output registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            target      <= '0;
            wait_cnt    <= '0;
            in_cycle    <= '0;
            op          <= OP_NOP;
            data        <= '0;
            rt_sel      <= '0;
            rt_ready    <= 1'b0;
            busy        <= 1'b0;
            sim_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            target      <= target_nxt;
            wait_cnt    <= wait_cnt_nxt;
            in_cycle    <= in_cycle_nxt;
            op          <= op_nxt;
            data        <= data_nxt;
            rt_sel      <= rt_sel_nxt;
            rt_ready    <= rt_ready_nxt;
            busy        <= busy_nxt;
            sim_done    <= sim_done_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_noc_cycle_sequencer.sv
// tb_noc_cycle_sequencer
// Directed and randomized runs of the sequencer. A plan (table entries, gaps,
// per-cycle done delays) drives the DUT; a monitor records every non-NOP
// command; the expected command list and its timing are derived from the plan.

module tb_noc_cycle_sequencer;

    localparam int NR  = 16;
    localparam int TMO = 8;

    localparam logic [2:0] OP_NOP          = 3'd0;
    localparam logic [2:0] OP_INIT         = 3'd1;
    localparam logic [2:0] OP_LOAD_RT      = 3'd2;
    localparam logic [2:0] OP_LOAD_STAGING = 3'd3;
    localparam logic [2:0] OP_PHASE0       = 3'd4;
    localparam logic [2:0] OP_PHASE1       = 3'd5;

    typedef struct {
        logic [2:0]    op;
        logic [31:0]   data;
        logic [NR-1:0] sel;
        logic [13:0]   cyc_v;
        int            stamp;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [13:0]   num_cycles;
    logic          rt_valid;
    logic          rt_ready;
    logic [31:0]   rt_data;
    logic [3:0]    rt_dest;
    logic          rt_last;
    logic [NR-1:0] router_done;
    logic [2:0]    op;
    logic [31:0]   data;
    logic [NR-1:0] rt_sel;
    logic [13:0]   in_cycle;
    logic          busy;
    logic          sim_done;
    logic          timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ev_t ev_q[$];
    int  sd_cnt   = 0;
    int  sd_stamp = 0;

    int  d_q[$];
    int  d_idx    = 0;
    int  wk       = 0;
    bit  waiting  = 0;
    bit  stuck    = 0;
    bit  use_fffe = 0;

    logic [3:0]  plan_dest[$];
    logic [31:0] plan_data[$];
    int          plan_gap[$];

    noc_cycle_sequencer #(.NUM_ROUTERS(NR), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_cycles (num_cycles),
        .rt_valid   (rt_valid),
        .rt_ready   (rt_ready),
        .rt_data    (rt_data),
        .rt_dest    (rt_dest),
        .rt_last    (rt_last),
        .router_done(router_done),
        .op         (op),
        .data       (data),
        .rt_sel     (rt_sel),
        .in_cycle   (in_cycle),
        .busy       (busy),
        .sim_done   (sim_done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: record commands, count done pulses, check bus invariants.
    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n === 1'b1) begin
            if (op != OP_NOP) begin
                e.op = op; e.data = data; e.sel = rt_sel; e.cyc_v = in_cycle; e.stamp = cyc;
                ev_q.push_back(e);
                check("busy_during_cmd", 32'(busy), 32'd1);
            end
            if (sim_done) begin
                sd_cnt++;
                sd_stamp = cyc;
            end
            if (op != OP_LOAD_RT) check("data_zero", data, 32'd0);
            if (rt_ready && op == OP_NOP) check("gap_sel", 32'(rt_sel), 32'd0);
            if (op != OP_NOP && op != OP_LOAD_RT) check("ready_low", 32'(rt_ready), 32'd0);
        end
    end

    function automatic logic [NR-1:0] partial_done();
        logic [NR-1:0] v;
        if (use_fffe) return {{(NR-1){1'b1}}, 1'b0};
        v = NR'($urandom);
        v[$urandom_range(0, NR-1)] = 1'b0;
        return v;
    endfunction

    // Router model: after each Phase1, done stays incomplete for d cycles.
    always @(negedge clk) begin
        if (stuck) begin
            router_done = '0;
        end else if (op == OP_PHASE1) begin
            waiting     = 1'b1;
            wk          = 0;
            router_done = partial_done();
        end else if (waiting) begin
            if (wk >= ((d_idx < d_q.size()) ? d_q[d_idx] : 0)) begin
                router_done = '1;
                waiting     = 1'b0;
                d_idx++;
            end else begin
                router_done = partial_done();
            end
            wk++;
        end
    end

    task automatic clear_plan();
        plan_dest.delete(); plan_data.delete(); plan_gap.delete(); d_q.delete();
    endtask

    task automatic add_entry(input logic [3:0] dest, input int gap);
        plan_dest.push_back(dest);
        plan_data.push_back({12'd0, 6'($urandom_range(0, 63)), 14'($urandom_range(0, 16383))});
        plan_gap.push_back(gap);
    endtask

    task automatic plan_random(input int n_ent, input int n, input int max_gap, input int max_d);
        clear_plan();
        for (int e = 0; e < n_ent; e++) add_entry(4'($urandom_range(0, NR-1)), $urandom_range(0, max_gap));
        for (int c = 0; c < n; c++) d_q.push_back($urandom_range(0, max_d));
    endtask

    task automatic reset_book();
        ev_q.delete(); sd_cnt = 0; d_idx = 0; waiting = 1'b0;
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        reset_book();
        num_cycles = 14'(n);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_entries();
        int t;
        for (int e = 0; e < plan_dest.size(); e++) begin
            rt_valid = 1'b0;
            repeat (plan_gap[e]) @(negedge clk);
            t = 0;
            while (!rt_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("rt_ready_seen", 32'(rt_ready), 32'd1);
            rt_dest  = plan_dest[e];
            rt_data  = plan_data[e];
            rt_last  = (e == plan_dest.size() - 1);
            rt_valid = 1'b1;
            @(negedge clk);
        end
        rt_valid = 1'b0;
        rt_last  = 1'b0;
    endtask

    task automatic wait_sd(input int target, input int budget);
        int t = 0;
        while (sd_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("sim_done_seen", 32'(sd_cnt >= target), 32'd1);
    endtask

    // Expected command list and timing from the plan.
    task automatic compare_events(input int n);
        ev_t exp_q[$];
        ev_t e;
        int  ne = plan_dest.size();
        int  base, s, nxt, last_rt;
        e.stamp = 0;
        e.op = OP_INIT; e.data = 0; e.sel = '1; e.cyc_v = 0; exp_q.push_back(e);
        for (int i = 0; i < ne; i++) begin
            e.op = OP_LOAD_RT; e.data = plan_data[i]; e.sel = NR'(1) << plan_dest[i]; e.cyc_v = 0;
            exp_q.push_back(e);
        end
        for (int c = 0; c < n; c++) begin
            e.data = 0; e.sel = '1; e.cyc_v = 14'(c);
            e.op = OP_LOAD_STAGING; exp_q.push_back(e);
            e.op = OP_PHASE0;       exp_q.push_back(e);
            e.op = OP_PHASE1;       exp_q.push_back(e);
        end
        check("ev_count", ev_q.size(), exp_q.size());
        if (ev_q.size() != exp_q.size()) return;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("ev%0d_op", i),    32'(ev_q[i].op),    32'(exp_q[i].op));
            check($sformatf("ev%0d_sel", i),   32'(ev_q[i].sel),   32'(exp_q[i].sel));
            check($sformatf("ev%0d_data", i),  ev_q[i].data,       exp_q[i].data);
            check($sformatf("ev%0d_cycle", i), 32'(ev_q[i].cyc_v), 32'(exp_q[i].cyc_v));
        end
        for (int i = 1; i < ne; i++)
            check($sformatf("rt_spacing%0d", i), ev_q[1+i].stamp - ev_q[i].stamp, plan_gap[i] + 1);
        last_rt = ev_q[ne].stamp;
        base    = 1 + ne;
        if (n == 0) begin
            check("finish_after_rt", sd_stamp - last_rt, 1);
        end else begin
            check("stage_after_rt", ev_q[base].stamp - last_rt, 1);
            for (int c = 0; c < n; c++) begin
                s   = ev_q[base + 3*c].stamp;
                check($sformatf("ph0_t%0d", c), ev_q[base + 3*c + 1].stamp - s, 1);
                check($sformatf("ph1_t%0d", c), ev_q[base + 3*c + 2].stamp - s, 2);
                nxt = (c < n - 1) ? ev_q[base + 3*c + 3].stamp : sd_stamp;
                check($sformatf("wait_t%0d", c), nxt - (s + 2), d_q[c] + 2);
            end
        end
    endtask

    task automatic do_run(input int n);
        start_run(n);
        check("init_op", 32'(op), 32'(OP_INIT));
        check("busy_run", 32'(busy), 32'd1);
        check("tmo_cleared", 32'(timeout_err), 32'd0);
        send_entries();
        wait_sd(1, 4000);
        repeat (2) @(negedge clk);
        check("sd_pulses", sd_cnt, 1);
        check("idle_busy", 32'(busy), 32'd0);
        check("final_in_cycle", 32'(in_cycle), n);
        check("no_timeout", 32'(timeout_err), 32'd0);
        compare_events(n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit (observed hang, required finish)");
        $fatal(1);
    end

    initial begin
        int t, s, inits;
        rst_n = 1'b0; start = 1'b0; num_cycles = '0; rt_valid = 1'b0;
        rt_data = '0; rt_dest = '0; rt_last = 1'b0; router_done = '1;
        repeat (2) @(negedge clk);
        check("rst_op", 32'(op), 32'(OP_NOP));
        check("rst_data", data, 32'd0);
        check("rst_sel", 32'(rt_sel), 32'd0);
        check("rst_cycle", 32'(in_cycle), 32'd0);
        check("rst_ready", 32'(rt_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(sim_done), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three cycles, entries to routers 0 and 5, done always ready.
        clear_plan(); add_entry(4'd0, 0); add_entry(4'd5, 0);
        d_q = '{0, 0, 0};
        do_run(3);

        // Zero cycles: Init, LoadRt, then finish.
        clear_plan(); add_entry(4'($urandom_range(0, 15)), 0);
        do_run(0);

        // Two idle cycles between entries.
        clear_plan(); add_entry(4'd3, 1); add_entry(4'd9, 2); add_entry(4'd15, 2);
        d_q = '{1};
        do_run(1);

        // One router late for 5 cycles, then 7 (done wins at the timeout boundary).
        use_fffe = 1'b1;
        clear_plan(); add_entry(4'd7, 0);
        d_q = '{5, 7};
        do_run(2);
        use_fffe = 1'b0;

        // Asynchronous reset during Phase0 of the second simulated cycle.
        clear_plan(); add_entry(4'd2, 0);
        d_q = '{0, 0};
        start_run(2);
        send_entries();
        t = 0;
        while (!(op == OP_PHASE0 && in_cycle == 14'd1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ph0_reached", 32'(op == OP_PHASE0 && in_cycle == 14'd1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_op", 32'(op), 32'(OP_NOP));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cycle", 32'(in_cycle), 32'd0);
        check("abort_sel", 32'(rt_sel), 32'd0);
        check("abort_done", 32'(sim_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_op", 32'(op), 32'(OP_NOP));
        check("abort_no_pulse", sd_cnt, 0);

        // Routers never finish: timeout after TMO wait cycles.
        clear_plan(); add_entry(4'd4, 0);
        stuck = 1'b1;
        start_run(3);
        send_entries();
        wait_sd(1, 200);
        repeat (2) @(negedge clk);
        check("tmo_ev_count", ev_q.size(), 5);
        if (ev_q.size() == 5) begin
            check("tmo_last_op", 32'(ev_q[4].op), 32'(OP_PHASE1));
            check("tmo_latency", sd_stamp - ev_q[4].stamp, TMO + 1);
        end
        check("tmo_flag", 32'(timeout_err), 32'd1);
        check("tmo_cycle", 32'(in_cycle), 32'd0);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_pulses", sd_cnt, 1);
        stuck = 1'b0;
        repeat (5) @(negedge clk);
        check("tmo_sticky", 32'(timeout_err), 32'd1);

        // Randomized runs; the first also shows the next start clears the timeout.
        for (int r = 0; r < 6; r++) begin
            plan_random(1 + $urandom_range(0, 3), 0, 3, 7);
            t = $urandom_range(1, 4);
            for (int c = 0; c < t; c++) d_q.push_back($urandom_range(0, 7));
            do_run(t);
        end

        // start held high: ignored while busy, new run one cycle after IDLE.
        clear_plan(); add_entry(4'd11, 0);
        d_q = '{0};
        @(negedge clk);
        reset_book();
        num_cycles = 14'd1;
        start      = 1'b1;
        @(negedge clk);
        num_cycles = 14'd0;
        send_entries();
        wait_sd(1, 500);
        s = sd_stamp;
        t = 0;
        while (op != OP_INIT && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("restart_seen", 32'(op), 32'(OP_INIT));
        check("restart_gap", cyc - s, 2);
        inits = 0;
        foreach (ev_q[i]) if (ev_q[i].op == OP_INIT && ev_q[i].stamp < s) inits++;
        check("single_init", inits, 1);
        start = 1'b0;
        send_entries();
        wait_sd(2, 200);
        repeat (2) @(negedge clk);
        check("run2_cycle", 32'(in_cycle), 32'd0);
        check("run2_idle", 32'(busy), 32'd0);
        check("run2_pulses", sd_cnt, 2);
        if (ev_q.size() > 0) begin
            check("run2_last_op", 32'(ev_q[ev_q.size()-1].op), 32'(OP_LOAD_RT));
            check("run2_finish_t", sd_stamp - ev_q[ev_q.size()-1].stamp, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
